// File: rtl/mtsp_mem_pkg.sv
// Shared types, field positions and helpers for the Meitner memory-issue stage.
package mtsp_mem_pkg;

   localparam int unsigned CH_COUNT = 4;
   localparam int unsigned DEPTH    = 4;
   localparam int unsigned ID_W     = 4;
   localparam int unsigned ADDR_W   = 16;
   localparam int unsigned DATA_W   = 128;
   localparam int unsigned GPR_W    = 6;
   localparam int unsigned INDEX_W  = 8;
   localparam int unsigned MO_W     = 4;
   localparam int unsigned UINST_W  = 26;
   localparam int unsigned PTR_W    = $clog2(DEPTH);
   localparam int unsigned CNT_W    = PTR_W + 1;

   // UINST layout: [7:0] index, [15:8] upper address, [19:16] MO, [20] nEN, [21] write, [25:22] ID
   localparam int unsigned UINST_MO_LSB = 16;
   localparam int unsigned UINST_NEN    = 20;
   localparam int unsigned UINST_WRITE  = 21;
   localparam int unsigned UINST_ID_LSB = 22;

   localparam logic [MO_W-1:0] MO_MEM = 4'h5;

   typedef enum logic [ID_W-1:0] {
      MEMID_LMB     = 4'd0,
      MEMID_SCRATCH = 4'd1,
      MEMID_STREAM  = 4'd2,
      MEMID_PACK    = 4'd3
   } mem_id_e;

   localparam logic [ID_W-1:0] MEMID_LIMIT = ID_W'(CH_COUNT);

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [GPR_W-1:0]  src;
      logic [DATA_W-1:0] data0;
      logic [DATA_W-1:0] data1;
   } mem_req_t;

   // Relative index wraps within the index field; upper address bits pass through.
   function automatic logic [ADDR_W-1:0] calc_addr(input logic [ADDR_W-1:0]  base,
                                                   input logic [INDEX_W-1:0] rel);
      logic [INDEX_W-1:0] idx;
      idx = base[INDEX_W-1:0] + rel;
      return {base[ADDR_W-1:INDEX_W], idx};
   endfunction

endpackage

// File: rtl/mtsp_mem_req_fifo.sv
// Per-channel request FIFO with a registered head entry and valid/ready pop.
module mtsp_mem_req_fifo
   import mtsp_mem_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  mem_req_t din,
   input  logic     ready,
   output logic     valid,
   output mem_req_t head,
   output logic     full_c,
   output logic     busy_nxt_c
);

   mem_req_t           mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   rd_nxt;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               pop;
   logic               load_din;
   logic               load_mem;

   assign pop        = valid && ready;
   assign rd_nxt     = rd_ptr + PTR_W'(1);
   assign cnt_nxt    = count + CNT_W'(push) - CNT_W'(pop);
   assign full_c     = (count == CNT_W'(DEPTH));
   assign busy_nxt_c = (cnt_nxt != '0);

   // Head reloads from the incoming request when it becomes the oldest entry.
   assign load_din = push && ((count == '0) || (pop && (count == CNT_W'(1))));
   assign load_mem = pop && (count > CNT_W'(1));

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         valid  <= 1'b0;
         head   <= '0;
      end else begin
         count <= cnt_nxt;
         valid <= (cnt_nxt != '0);
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_nxt;
         end
         if (load_din) begin
            head <= din;
         end else if (load_mem) begin
            head <= mem[rd_nxt];
         end
      end
   end

endmodule

// File: rtl/mtsp_mem_issue.sv
// Memory-operation issue stage: decodes MO_MEM, forms address/source and routes to channel FIFOs.
module mtsp_mem_issue
   import mtsp_mem_pkg::*;
(
   input  logic                         CLK,
   input  logic                         nRST,
   input  logic [UINST_W-1:0]           UINST,
   input  logic [GPR_W-1:0]             REF_ADDR_DEST,
   input  logic [INDEX_W-1:0]           REF_ADDR_RELATIVE,
   input  logic [GPR_W-1:0]             REF_MEM_SRC,
   input  logic [DATA_W-1:0]            SRC0,
   input  logic [DATA_W-1:0]            SRC1,
   output logic                         STALL,
   output logic [CH_COUNT-1:0]          MEM_VALID,
   input  logic [CH_COUNT-1:0]          MEM_READY,
   output logic [CH_COUNT-1:0]          MEM_WRITE,
   output logic [CH_COUNT*ADDR_W-1:0]   MEM_ADDR,
   output logic [CH_COUNT*GPR_W-1:0]    MEM_SRC,
   output logic [CH_COUNT*DATA_W-1:0]   MEM_DATA_0,
   output logic [CH_COUNT*DATA_W-1:0]   MEM_DATA_1,
   output logic                         BUSY,
   output logic                         ERR_ID
);

   logic                req_c;
   logic [ID_W-1:0]     id;
   logic                id_ok;
   mem_req_t            req_pl;
   logic [CH_COUNT-1:0] hit;
   logic [CH_COUNT-1:0] push;
   logic [CH_COUNT-1:0] full;
   logic [CH_COUNT-1:0] busy_nxt;
   mem_req_t            head [CH_COUNT];

   assign req_c = !UINST[UINST_NEN] && (UINST[UINST_MO_LSB +: MO_W] == MO_MEM);
   assign id    = UINST[UINST_ID_LSB +: ID_W];
   assign id_ok = (id < MEMID_LIMIT);

   always_comb begin
      req_pl       = '0;
      req_pl.write = UINST[UINST_WRITE];
      req_pl.addr  = calc_addr(UINST[ADDR_W-1:0], REF_ADDR_RELATIVE);
      req_pl.src   = REF_MEM_SRC + REF_ADDR_DEST;
      req_pl.data0 = SRC0;
      req_pl.data1 = SRC1;
   end

   for (genvar c = 0; c < CH_COUNT; c++) begin : g_ch
      assign hit[c]  = req_c && (id == ID_W'(c));
      assign push[c] = hit[c] && !full[c];

      mtsp_mem_req_fifo u_fifo (
         .clk        (CLK),
         .rst_n      (nRST),
         .push       (push[c]),
         .din        (req_pl),
         .ready      (MEM_READY[c]),
         .valid      (MEM_VALID[c]),
         .head       (head[c]),
         .full_c     (full[c]),
         .busy_nxt_c (busy_nxt[c])
      );

      assign MEM_WRITE[c]                    = head[c].write;
      assign MEM_ADDR[c*ADDR_W +: ADDR_W]    = head[c].addr;
      assign MEM_SRC[c*GPR_W +: GPR_W]       = head[c].src;
      assign MEM_DATA_0[c*DATA_W +: DATA_W]  = head[c].data0;
      assign MEM_DATA_1[c*DATA_W +: DATA_W]  = head[c].data1;
   end

   // A full target stalls even if it drains this cycle; no pop-to-push bypass.
   assign STALL = |(hit & full);

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         BUSY   <= 1'b0;
         ERR_ID <= 1'b0;
      end else begin
         BUSY <= |busy_nxt;
         if (req_c && !id_ok) begin
            ERR_ID <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mtsp_mem_issue.sv
// Directed table plus scoreboard-checked sequences for mtsp_mem_issue.
module tb_mtsp_mem_issue;
   import mtsp_mem_pkg::*;

   logic                        CLK;
   logic                        nRST;
   logic [UINST_W-1:0]          UINST;
   logic [GPR_W-1:0]            REF_ADDR_DEST;
   logic [INDEX_W-1:0]          REF_ADDR_RELATIVE;
   logic [GPR_W-1:0]            REF_MEM_SRC;
   logic [DATA_W-1:0]           SRC0;
   logic [DATA_W-1:0]           SRC1;
   logic                        STALL;
   logic [CH_COUNT-1:0]         MEM_VALID;
   logic [CH_COUNT-1:0]         MEM_READY;
   logic [CH_COUNT-1:0]         MEM_WRITE;
   logic [CH_COUNT*ADDR_W-1:0]  MEM_ADDR;
   logic [CH_COUNT*GPR_W-1:0]   MEM_SRC;
   logic [CH_COUNT*DATA_W-1:0]  MEM_DATA_0;
   logic [CH_COUNT*DATA_W-1:0]  MEM_DATA_1;
   logic                        BUSY;
   logic                        ERR_ID;

   logic [3:0] drv_id;
   logic       drv_wr;
   logic       drv_nen;
   logic [3:0] drv_mo;
   logic [7:0] drv_upper;
   logic [7:0] drv_index;

   assign UINST = {drv_id, drv_wr, drv_nen, drv_mo, drv_upper, drv_index};

   mtsp_mem_issue dut (
      .CLK               (CLK),
      .nRST              (nRST),
      .UINST             (UINST),
      .REF_ADDR_DEST     (REF_ADDR_DEST),
      .REF_ADDR_RELATIVE (REF_ADDR_RELATIVE),
      .REF_MEM_SRC       (REF_MEM_SRC),
      .SRC0              (SRC0),
      .SRC1              (SRC1),
      .STALL             (STALL),
      .MEM_VALID         (MEM_VALID),
      .MEM_READY         (MEM_READY),
      .MEM_WRITE         (MEM_WRITE),
      .MEM_ADDR          (MEM_ADDR),
      .MEM_SRC           (MEM_SRC),
      .MEM_DATA_0        (MEM_DATA_0),
      .MEM_DATA_1        (MEM_DATA_1),
      .BUSY              (BUSY),
      .ERR_ID            (ERR_ID)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [5:0]  src;
      logic [127:0] d0;
      logic [127:0] d1;
   } exp_t;

   typedef struct {
      logic [3:0]  id;
      logic        wr;
      logic [3:0]  mo;
      logic [7:0]  upper;
      logic [7:0]  index;
      logic [7:0]  rel;
      logic [5:0]  dest;
      logic [5:0]  msrc;
      logic [31:0] seed;
      logic [3:0]  exp_mask;
      logic [15:0] exp_addr;
      logic [5:0]  exp_src;
      logic        exp_err;
   } vec_t;

   exp_t q [CH_COUNT][$];
   logic err_exp    = 1'b0;
   logic last_stall = 1'b0;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk_exp();
      exp_t e;
      logic [7:0] idx;
      idx    = drv_index + REF_ADDR_RELATIVE;
      e.wr   = drv_wr;
      e.addr = {drv_upper, idx};
      e.src  = REF_MEM_SRC + REF_ADDR_DEST;
      e.d0   = SRC0;
      e.d1   = SRC1;
      return e;
   endfunction

   task automatic set_req(input logic [3:0] id, input logic wr, input logic [3:0] mo,
                          input logic [7:0] upper, input logic [7:0] index, input logic [7:0] rel,
                          input logic [5:0] dest, input logic [5:0] msrc, input logic [31:0] seed);
      drv_id = id; drv_wr = wr; drv_nen = 1'b0; drv_mo = mo;
      drv_upper = upper; drv_index = index; REF_ADDR_RELATIVE = rel;
      REF_ADDR_DEST = dest; REF_MEM_SRC = msrc;
      SRC0 = {4{seed}}; SRC1 = ~{4{seed}};
   endtask

   task automatic idle();
      drv_nen = 1'b1;
      drv_mo  = 4'h0;
   endtask

   // One clock: check outputs against the scoreboard, advance, update the model.
   task automatic cycle();
      logic req;
      int   id;
      logic stall;
      logic [CH_COUNT-1:0] pop;
      #1;
      req   = !drv_nen && (drv_mo == MO_MEM);
      id    = int'(drv_id);
      stall = 1'b0;
      if (req && id < CH_COUNT) stall = (q[id].size() == DEPTH);
      chk("stall", STALL, stall);
      for (int c = 0; c < CH_COUNT; c++) begin
         chk($sformatf("valid_ch%0d", c), MEM_VALID[c], q[c].size() != 0);
         pop[c] = (q[c].size() != 0) && MEM_READY[c];
         if (q[c].size() != 0) begin
            chk($sformatf("addr_ch%0d", c), MEM_ADDR[c*ADDR_W +: ADDR_W], q[c][0].addr);
            chk($sformatf("src_ch%0d", c), MEM_SRC[c*GPR_W +: GPR_W], q[c][0].src);
            chk($sformatf("write_ch%0d", c), MEM_WRITE[c], q[c][0].wr);
            chk($sformatf("data0_ch%0d", c), MEM_DATA_0[c*DATA_W +: DATA_W], q[c][0].d0);
            chk($sformatf("data1_ch%0d", c), MEM_DATA_1[c*DATA_W +: DATA_W], q[c][0].d1);
         end
      end
      @(posedge CLK);
      #1;
      for (int c = 0; c < CH_COUNT; c++) if (pop[c]) void'(q[c].pop_front());
      if (req && id < CH_COUNT && !stall) q[id].push_back(mk_exp());
      if (req && id >= CH_COUNT) err_exp = 1'b1;
      last_stall = stall;
      chk("err_id", ERR_ID, err_exp);
      chk("busy", BUSY, (q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0);
   endtask

   task automatic drain(input string nm);
      idle();
      MEM_READY = '1;
      for (int k = 0; k < 20 && (q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0; k++)
         cycle();
      #1;
      chk(nm, MEM_VALID, 4'h0);
   endtask

   vec_t vecs [7];

   initial begin
      vecs[0] = '{4'd1, 1'b1, 4'h5, 8'hA1, 8'h3E, 8'h05, 6'h03, 6'h04, 32'h11111111, 4'b0010, 16'hA143, 6'h07, 1'b0};
      vecs[1] = '{4'd0, 1'b0, 4'h5, 8'h12, 8'hFF, 8'h01, 6'h3F, 6'h01, 32'h22222222, 4'b0001, 16'h1200, 6'h00, 1'b0};
      vecs[2] = '{4'd2, 1'b1, 4'h5, 8'hFF, 8'h80, 8'h80, 6'h20, 6'h21, 32'hDEADBEEF, 4'b0100, 16'hFF00, 6'h01, 1'b0};
      vecs[3] = '{4'd3, 1'b0, 4'h5, 8'h00, 8'h10, 8'h0F, 6'h0A, 6'h05, 32'h0BADF00D, 4'b1000, 16'h001F, 6'h0F, 1'b0};
      vecs[4] = '{4'd1, 1'b0, 4'h3, 8'h7E, 8'hFE, 8'h03, 6'h10, 6'h10, 32'h12345678, 4'b0000, 16'h0000, 6'h00, 1'b0};
      vecs[5] = '{4'd4, 1'b1, 4'h5, 8'h33, 8'h01, 8'h01, 6'h01, 6'h01, 32'hCAFEF00D, 4'b0000, 16'h0000, 6'h00, 1'b1};
      vecs[6] = '{4'd1, 1'b0, 4'h5, 8'h7E, 8'hFE, 8'h03, 6'h10, 6'h10, 32'h5A5A5A5A, 4'b0010, 16'h7E01, 6'h20, 1'b1};

      nRST = 1'b0;
      MEM_READY = '1;
      set_req(4'd0, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 6'h00, 6'h00, 32'h0);
      idle();
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_valid", MEM_VALID, 4'h0);
      chk("rst_write", MEM_WRITE, 4'h0);
      chk("rst_addr", MEM_ADDR, 64'h0);
      chk("rst_src", MEM_SRC, 24'h0);
      chk("rst_data0", MEM_DATA_0, '0);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_err", ERR_ID, 1'b0);
      nRST = 1'b1;
      chk("rst_stall", STALL, 1'b0);

      // Directed single requests with hand-computed payloads.
      for (int i = 0; i < 7; i++) begin
         int ch;
         set_req(vecs[i].id, vecs[i].wr, vecs[i].mo, vecs[i].upper, vecs[i].index, vecs[i].rel,
                 vecs[i].dest, vecs[i].msrc, vecs[i].seed);
         MEM_READY = '1;
         cycle();
         ch = int'(vecs[i].id[1:0]);
         chk($sformatf("vec%0d_mask", i), MEM_VALID, vecs[i].exp_mask);
         chk($sformatf("vec%0d_err", i), ERR_ID, vecs[i].exp_err);
         if (vecs[i].exp_mask != 4'h0) begin
            chk($sformatf("vec%0d_addr", i), MEM_ADDR[ch*ADDR_W +: ADDR_W], vecs[i].exp_addr);
            chk($sformatf("vec%0d_src", i), MEM_SRC[ch*GPR_W +: GPR_W], vecs[i].exp_src);
            chk($sformatf("vec%0d_wr", i), MEM_WRITE[ch], vecs[i].wr);
            chk($sformatf("vec%0d_d0", i), MEM_DATA_0[ch*DATA_W +: DATA_W], {4{vecs[i].seed}});
         end
         idle();
         cycle();
      end

      // Back-pressure: fill channel 0, fifth request stalls until a slot frees.
      MEM_READY = 4'h0;
      for (int i = 0; i < 4; i++) begin
         set_req(4'd0, 1'b1, 4'h5, 8'h12, 8'(i * 16), 8'h00, 6'(i), 6'h00, 32'(i + 1));
         cycle();
      end
      set_req(4'd0, 1'b1, 4'h5, 8'h12, 8'h50, 8'h00, 6'h05, 6'h00, 32'h5);
      #1;
      chk("bp_stall5", STALL, 1'b1);
      cycle();
      chk("bp_head_held", MEM_ADDR[ADDR_W-1:0], 16'h1200);
      MEM_READY[0] = 1'b1;
      for (int k = 0; k < 10 && last_stall; k++) cycle();
      chk("bp_accept", last_stall, 1'b0);
      drain("bp_drained");

      // Concurrent channels 0/2/3 with random ready; requests held while stalled.
      for (int i = 0; i < 60; i++) begin
         if (!last_stall) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            set_req(4'(sel == 0 ? 0 : sel + 1), 1'($urandom), ($urandom_range(0, 3) != 0) ? 4'h5 : 4'h0,
                    8'($urandom), 8'($urandom), 8'($urandom), 6'($urandom), 6'($urandom), $urandom);
         end
         MEM_READY = 4'($urandom);
         cycle();
      end
      drain("conc_drained");

      // Reset mid-burst with three pending in channel 2.
      MEM_READY = 4'h0;
      for (int i = 0; i < 3; i++) begin
         set_req(4'd2, 1'b0, 4'h5, 8'h40, 8'(i), 8'h00, 6'h00, 6'h00, 32'(i));
         cycle();
      end
      chk("mid_busy", BUSY, 1'b1);
      idle();
      nRST = 1'b0;
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      for (int c = 0; c < CH_COUNT; c++) q[c].delete();
      err_exp = 1'b0;
      last_stall = 1'b0;
      chk("mid_rst_valid", MEM_VALID, 4'h0);
      chk("mid_rst_busy", BUSY, 1'b0);
      chk("mid_rst_err", ERR_ID, 1'b0);
      set_req(4'd1, 1'b1, 4'h5, 8'h99, 8'h01, 8'h02, 6'h01, 6'h01, 32'hABCD0123);
      cycle();
      chk("post_rst_valid", MEM_VALID, 4'b0010);
      chk("post_rst_addr", MEM_ADDR[ADDR_W +: ADDR_W], 16'h9903);
      drain("post_rst_drained");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
